// File: rtl/gpu_pkg.sv
// gpu_pkg: shared types, defaults and helpers for the core's warp arbitration logic.
package gpu_pkg;

    typedef enum logic {WA_ARB, WA_HELD} warp_arb_state_t;

    localparam int DEF_NUM_WARPS = 2;
    localparam int MAX_WARPS     = 32;

    function automatic int onehot2idx(input logic [MAX_WARPS-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_WARPS; i++)
            if (oh[i]) idx = i;
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority encoder; picks the first request at or after ptr.
module rr_pick #(
    parameter  int N = 2,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [W:0] c;

    // Scan from the farthest position back to ptr so the nearest hit wins.
    always_comb begin
        found = |req;
        idx   = ptr;
        c     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            c = {1'b0, ptr} + (W+1)'(i);
            if (c >= (W+1)'(N)) c = c - (W+1)'(N);
            if (req[c[W-1:0]]) idx = c[W-1:0];
        end
    end

endmodule

// File: rtl/warp_issue_arbiter.sv
// warp_issue_arbiter: round-robin owner of the shared decode/ALU/PC path across resident warps,
// with early release, activity tracking and a sticky hung-grant flag.
module warp_issue_arbiter
    import gpu_pkg::*;
#(
    parameter  int NUM_WARPS = DEF_NUM_WARPS,
    parameter  int MAX_HOLD  = 64,
    parameter  int CNT_BITS  = 16,
    localparam int SW        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_WARPS-1:0]          start,
    input  logic [NUM_WARPS-1:0]          done,
    input  logic [NUM_WARPS-1:0]          issue_req,
    input  logic [NUM_WARPS-1:0]          rel,
    output logic [NUM_WARPS-1:0]          grant,
    output logic                          grant_valid,
    output logic [SW-1:0]                 warp_select,
    output logic [NUM_WARPS-1:0]          active,
    output logic                          all_done,
    output logic                          hang_err,
    output logic [NUM_WARPS*CNT_BITS-1:0] issue_cnt
);

    warp_arb_state_t       state_q, state_d;
    logic [NUM_WARPS-1:0]  grant_q, grant_d, active_q, active_d, elig;
    logic [SW-1:0]         sel_q, sel_d, ptr_q, ptr_d, win, holder;
    logic [HW-1:0]         hold_q, hold_d;
    logic                  started_q, started_d, all_done_q, all_done_d, hang_q, hang_d;
    logic                  found, ending;
    logic [CNT_BITS-1:0]   cnt_q [NUM_WARPS];
    logic [CNT_BITS-1:0]   cnt_d [NUM_WARPS];

    assign elig   = issue_req & active_q;
    assign holder = SW'(onehot2idx(MAX_WARPS'(grant_q)));
    assign ending = rel[holder] | done[holder];

    rr_pick #(.N(NUM_WARPS)) u_pick (
        .req  (elig),
        .ptr  (ptr_q),
        .found(found),
        .idx  (win)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        hold_d     = hold_q;
        cnt_d      = cnt_q;
        active_d   = (active_q & ~done) | start;
        started_d  = started_q | (|start);
        all_done_d = started_q && (active_q == '0) && (start == '0);
        if (state_q == WA_ARB) begin
            if (found) begin
                state_d    = WA_HELD;
                grant_d    = NUM_WARPS'(1) << win;
                sel_d      = win;
                cnt_d[win] = (&cnt_q[win]) ? cnt_q[win] : cnt_q[win] + 1'b1;
            end
        end else if (ending) begin
            // Releasing warp drops to lowest priority for the next round.
            state_d = WA_ARB;
            grant_d = '0;
            ptr_d   = (holder == SW'(NUM_WARPS - 1)) ? '0 : holder + 1'b1;
            hold_d  = '0;
        end else begin
            hold_d = (hold_q == HW'(MAX_HOLD - 1)) ? hold_q : hold_q + 1'b1;
        end
        hang_d = hang_q | (state_q == WA_HELD && !ending && hold_d == HW'(MAX_HOLD - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= WA_ARB;
            grant_q    <= '0;
            sel_q      <= '0;
            ptr_q      <= '0;
            hold_q     <= '0;
            active_q   <= '0;
            started_q  <= 1'b0;
            all_done_q <= 1'b0;
            hang_q     <= 1'b0;
            cnt_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            hold_q     <= hold_d;
            active_q   <= active_d;
            started_q  <= started_d;
            all_done_q <= all_done_d;
            hang_q     <= hang_d;
            cnt_q      <= cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign warp_select = sel_q;
    assign active      = active_q;
    assign all_done    = all_done_q;
    assign hang_err    = hang_q;

    for (genvar g = 0; g < NUM_WARPS; g++) begin : g_cnt
        assign issue_cnt[g*CNT_BITS +: CNT_BITS] = cnt_q[g];
    end

endmodule

// File: tb/tb_warp_issue_arbiter.sv
// tb_warp_issue_arbiter: directed scenarios plus randomized traffic against a queue-free
// behavioural model that tracks the current owner as a plain warp number.
module tb_warp_issue_arbiter;

    localparam int NW = 3;
    localparam int MH = 64;
    localparam int CB = 4;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NW-1:0]     start = '0, done = '0, issue_req = '0, rel = '0;
    logic [NW-1:0]     grant, active;
    logic              grant_valid, all_done, hang_err;
    logic [SW-1:0]     warp_select;
    logic [NW*CB-1:0]  issue_cnt;

    int total = 0;
    int bad   = 0;

    logic [NW-1:0] m_act;
    bit            m_started, m_hang, m_alld;
    int            m_hold, m_ptr, m_sel, m_held;
    int            m_cnt [NW];

    warp_issue_arbiter #(.NUM_WARPS(NW), .MAX_HOLD(MH), .CNT_BITS(CB)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .done       (done),
        .issue_req  (issue_req),
        .rel        (rel),
        .grant      (grant),
        .grant_valid(grant_valid),
        .warp_select(warp_select),
        .active     (active),
        .all_done   (all_done),
        .hang_err   (hang_err),
        .issue_cnt  (issue_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NW-1:0] m_grant();
        return (m_hold < 0) ? '0 : NW'(1 << m_hold);
    endfunction

    task automatic m_reset();
        m_act = '0; m_started = 0; m_hang = 0; m_alld = 0;
        m_hold = -1; m_ptr = 0; m_sel = 0; m_held = 0;
        foreach (m_cnt[w]) m_cnt[w] = 0;
    endtask

    task automatic m_step(input logic [NW-1:0] s, d, r, l);
        logic [NW-1:0] el;
        bit            nall;
        nall = m_started && (m_act == '0) && (s == '0);
        if (m_hold < 0) begin
            el = r & m_act;
            for (int k = 0; k < NW; k++) begin
                int w;
                w = (m_ptr + k) % NW;
                if (m_hold < 0 && el[w]) begin
                    m_hold = w; m_sel = w; m_held = 0;
                    if (m_cnt[w] < (1 << CB) - 1) m_cnt[w]++;
                end
            end
        end else if (l[m_hold] || d[m_hold]) begin
            m_ptr  = (m_hold + 1) % NW;
            m_hold = -1;
            m_held = 0;
        end else begin
            if (m_held < MH - 1) m_held++;
            if (m_held == MH - 1) m_hang = 1;
        end
        m_act     = (m_act & ~d) | s;
        m_started = m_started | (|s);
        m_alld    = nall;
    endtask

    task automatic cmp_all();
        chk("grant", grant, m_grant());
        chk("grant_valid", grant_valid, m_hold >= 0);
        chk("warp_select", warp_select, m_sel);
        chk("active", active, m_act);
        chk("all_done", all_done, m_alld);
        chk("hang_err", hang_err, m_hang);
        for (int w = 0; w < NW; w++) chk("issue_cnt", issue_cnt[w*CB +: CB], m_cnt[w]);
    endtask

    // Called at a negedge: drive, advance one clock, check at the next negedge.
    task automatic cyc(input logic [NW-1:0] s, d, r, l);
        start = s; done = d; issue_req = r; rel = l;
        m_step(s, d, r, l);
        @(posedge clk);
        @(negedge clk);
        cmp_all();
    endtask

    task automatic do_reset();
        reset = 1'b0; start = '0; done = '0; issue_req = '0; rel = '0;
        m_reset();
        @(negedge clk);
        @(negedge clk);
        cmp_all();
        reset = 1'b1;
    endtask

    logic [NW-1:0] exp2 [7] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b001, 3'b000, 3'b010};
    logic [NW-1:0] exp3 [5] = '{3'b010, 3'b010, 3'b000, 3'b010, 3'b000};
    logic [NW-1:0] rel3 [5] = '{3'b000, 3'b001, 3'b010, 3'b000, 3'b010};

    initial begin
        // 1: requests with nothing launched never win
        do_reset();
        for (int i = 0; i < 8; i++) cyc('0, '0, 3'b011, '0);
        chk("t1_grant", grant, 0);
        chk("t1_all_done", all_done, 0);

        // 2: two warps alternate, one bubble between grants
        do_reset();
        cyc(3'b011, '0, 3'b011, '0);
        for (int i = 0; i < 7; i++) begin
            cyc('0, '0, 3'b011, m_grant());
            chk("t2_seq", grant, exp2[i]);
        end
        chk("t2_cnt0", issue_cnt[0 +: CB], 2);
        chk("t2_cnt1", issue_cnt[CB +: CB], 2);

        // 3: lone warp1, spurious release from warp0 ignored
        do_reset();
        cyc(3'b010, '0, 3'b010, '0);
        for (int i = 0; i < 5; i++) begin
            cyc('0, '0, 3'b010, rel3[i]);
            chk("t3_seq", grant, exp3[i]);
        end

        // 4: grant held without release raises hang_err, grant kept
        do_reset();
        cyc(3'b001, '0, 3'b001, '0);
        cyc('0, '0, 3'b001, '0);
        chk("t4_grant", grant, 3'b001);
        for (int i = 0; i < 62; i++) cyc('0, '0, '0, '0);
        chk("t4_hang_pre", hang_err, 0);
        cyc('0, '0, '0, '0);
        chk("t4_hang", hang_err, 1);
        chk("t4_still", grant, 3'b001);
        for (int i = 0; i < 4; i++) cyc('0, '0, '0, '0);
        cyc('0, '0, '0, 3'b001);
        chk("t4_sticky", hang_err, 1);
        chk("t4_released", grant, 0);

        // 5: done ends the grant; all_done follows the last done by one cycle
        do_reset();
        cyc(3'b011, '0, '0, '0);
        cyc('0, '0, 3'b001, '0);
        cyc('0, 3'b001, '0, '0);
        chk("t5_grant", grant, 0);
        chk("t5_active", active, 3'b010);
        cyc('0, 3'b010, '0, '0);
        chk("t5_ad_early", all_done, 0);
        cyc('0, '0, '0, '0);
        chk("t5_all_done", all_done, 1);
        cyc(3'b100, '0, '0, '0);
        chk("t5_ad_clear", all_done, 0);

        // 6: asynchronous reset mid-grant
        do_reset();
        cyc(3'b011, '0, 3'b011, '0);
        cyc('0, '0, 3'b011, '0);
        chk("t6_pre", grant, 3'b001);
        #2 reset = 1'b0;
        #1;
        chk("t6_grant", grant, 0);
        chk("t6_cnt", issue_cnt, 0);
        chk("t6_active", active, 0);
        m_reset();
        @(negedge clk);
        reset = 1'b1;
        cyc(3'b011, '0, 3'b011, '0);
        cyc('0, '0, 3'b011, '0);
        chk("t6_first", grant, 3'b001);
        chk("t6_sel", warp_select, 0);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [NW-1:0] s, d, l;
            for (int w = 0; w < NW; w++) begin
                s[w] = ($urandom_range(0, 19) == 0);
                d[w] = ($urandom_range(0, 24) == 0);
            end
            l = ($urandom_range(0, 9) < 4) ? m_grant() : '0;
            if ($urandom_range(0, 7) == 0) l = l | NW'($urandom);
            cyc(s, d, NW'($urandom | $urandom), l);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
